// File: rtl/alu_flag_stack.sv
// Save/restore stack for the ALU condition flags and the interrupt-enable bit.
// Push is single-cycle; pop reads synchronously and then issues a one-cycle restore strobe.
module alu_flag_stack #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_n,
  input  logic             flag_v,
  input  logic             ie_in,
  output logic [3:0]       flag_dout,
  output logic             flag_wr,
  output logic             ie_dout,
  output logic             ie_wr,
  output logic             busy,
  output logic [CNT_W-1:0] level,
  output logic             empty,
  output logic             full,
  input  logic             err_clr,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             proto_err
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int Z_FLAG = 0;
  localparam int C_FLAG = 1;
  localparam int N_FLAG = 2;
  localparam int V_FLAG = 3;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state, state_nxt;
  logic [4:0]       mem [DEPTH];
  logic [AW-1:0]    rd_addr_p0;
  logic [4:0]       rd_data_p1;
  logic             do_push, do_pop;
  logic             ovf_set, unf_set, proto_set;
  logic [CNT_W-1:0] level_nxt;

  // Requests are only honoured in IDLE; a simultaneous push is dropped in favour of the pop.
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    proto_set = 1'b0;
    level_nxt = level;
    busy      = 1'b0;
    flag_wr   = 1'b0;
    ie_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          proto_set = push;
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            do_pop    = 1'b1;
            level_nxt = level - CNT_W'(1);
            state_nxt = RD;
          end
        end else if (push) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            do_push   = 1'b1;
            level_nxt = level + CNT_W'(1);
          end
        end
      end
      RD: begin
        busy      = 1'b1;
        proto_set = push | pop;
        state_nxt = WR;
      end
      WR: begin
        busy      = 1'b1;
        flag_wr   = 1'b1;
        ie_wr     = 1'b1;
        proto_set = push | pop;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      empty     <= (level_nxt == '0);
      full      <= (level_nxt == CNT_W'(DEPTH));
      ovf_err   <= (ovf_err & ~err_clr) | ovf_set;
      unf_err   <= (unf_err & ~err_clr) | unf_set;
      proto_err <= (proto_err & ~err_clr) | proto_set;
    end
  end

  // Stage p0: write on push, latch the top-of-stack address on pop.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[level[AW-1:0]] <= {ie_in, flag_v, flag_n, flag_c, flag_z};
    if (do_pop)
      rd_addr_p0 <= level[AW-1:0] - AW'(1);
  end

  // Stage p1: synchronous read; the register holds the restored entry until the next pop.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data_p1 <= '0;
    else if (state == RD)
      rd_data_p1 <= mem[rd_addr_p0];
  end

  assign flag_dout[Z_FLAG] = rd_data_p1[0];
  assign flag_dout[C_FLAG] = rd_data_p1[1];
  assign flag_dout[N_FLAG] = rd_data_p1[2];
  assign flag_dout[V_FLAG] = rd_data_p1[3];
  assign ie_dout           = rd_data_p1[4];

endmodule

// File: tb/tb_alu_flag_stack.sv
// Bench for alu_flag_stack: vector table plus hand sequences, with a queue of expected
// restore entries checked whenever the restore strobe fires.
module tb_alu_flag_stack;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0, flag_v = 1'b0, ie_in = 1'b0;
  logic [3:0] flag_dout;
  logic flag_wr, ie_dout, ie_wr, busy, empty, full, ovf_err, unf_err, proto_err;
  logic [CNT_W-1:0] level;

  alu_flag_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v), .ie_in(ie_in),
    .flag_dout(flag_dout), .flag_wr(flag_wr), .ie_dout(ie_dout), .ie_wr(ie_wr),
    .busy(busy), .level(level), .empty(empty), .full(full), .err_clr(err_clr),
    .ovf_err(ovf_err), .unf_err(unf_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [4:0] mdl[$];
  logic [4:0] exp_q[$];

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [4:0] ent;
    int         lvl;
    logic       ovf;
    logic       unf;
    logic       proto;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic p, logic q, logic c, logic [4:0] e, int l,
                              logic o, logic u, logic pr);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.ent = e; v.lvl = l;
    v.ovf = o; v.unf = u; v.proto = pr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; the bench model decides which restore value is owed.
  task automatic drive(input logic p, input logic q, input logic c, input logic [4:0] e);
    push = p; pop = q; err_clr = c;
    {ie_in, flag_v, flag_n, flag_c, flag_z} = e;
    if (q) begin
      if (mdl.size() > 0) exp_q.push_back(mdl.pop_back());
    end else if (p) begin
      if (mdl.size() < DEPTH) mdl.push_back(e);
    end
    tick();
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic op(input logic p, input logic q, input logic c, input logic [4:0] e);
    drive(p, q, c, e);
    repeat (3) tick();
  endtask

  task automatic check_reset(input string name);
    check(name, {level, empty, full, flag_dout, flag_wr, ie_dout, ie_wr, busy,
                 ovf_err, unf_err, proto_err},
          {5'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  always @(negedge clk) begin
    if (!rst && flag_wr) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got entry %0h expected no strobe", {ie_dout, flag_dout});
      end else begin
        check("restore", {ie_wr, ie_dout, flag_dout}, {1'b1, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int s0;
    tbl[0]  = mk(0, 1, 0, 5'h00, 0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 1, 5'h00, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 5'h13, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 5'h0C, 2, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 5'h1F, 3, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 5'h00, 2, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 5'h00, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 5'h00, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 5'h01, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 5'h02, 2, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 5'h04, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 5'h00, 1, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 5'h00, 0, 0, 0, 0);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_reset("reset_state");

    s0 = strobes;
    for (int i = 0; i < 13; i++) begin
      op(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].ent);
      check($sformatf("v%0d_level", i), level, tbl[i].lvl);
      check($sformatf("v%0d_empty", i), empty, (tbl[i].lvl == 0));
      check($sformatf("v%0d_full", i), full, (tbl[i].lvl == DEPTH));
      check($sformatf("v%0d_errs", i), {ovf_err, unf_err, proto_err},
            {tbl[i].ovf, tbl[i].unf, tbl[i].proto});
    end
    check("table_strobe_count", strobes - s0, 5);

    // Single save/restore with strobe timing relative to the pop cycle.
    op(1, 0, 0, 5'h15);
    check("basic_level_push", level, 1);
    drive(0, 1, 0, 5'h00);
    check("basic_rd", {flag_wr, ie_wr, busy, level}, {1'b0, 1'b0, 1'b1, 5'd0});
    tick();
    check("basic_wr", {flag_wr, ie_wr, busy, flag_dout, ie_dout},
          {1'b1, 1'b1, 1'b1, 4'h5, 1'b1});
    tick();
    check("basic_after", {flag_wr, ie_wr, busy, flag_dout, ie_dout, empty},
          {1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1});

    // Overflow: DEPTH+1 pushes, the last one is dropped.
    for (int i = 0; i <= DEPTH; i++) op(1, 0, 0, 5'(i + 1));
    check("ovf_state", {full, empty, level, ovf_err}, {1'b1, 1'b0, 5'd16, 1'b1});
    op(0, 0, 1, 5'h00);
    check("ovf_clear", {full, level, ovf_err}, {1'b1, 5'd16, 1'b0});
    op(0, 1, 0, 5'h00);
    check("ovf_pop_level", level, 15);
    for (int i = 0; i < DEPTH - 1; i++) op(0, 1, 0, 5'h00);
    check("drained", {empty, level, unf_err}, {1'b1, 5'd0, 1'b0});

    // Push arriving in the RD state is ignored.
    op(1, 0, 0, 5'h0A);
    op(1, 0, 0, 5'h15);
    drive(0, 1, 0, 5'h00);
    push = 1'b1;
    {ie_in, flag_v, flag_n, flag_c, flag_z} = 5'h1E;
    tick();
    push = 1'b0;
    check("busy_push_rd", {proto_err, level}, {1'b1, 5'd1});
    repeat (2) tick();
    check("busy_push_after", {proto_err, level, busy}, {1'b1, 5'd1, 1'b0});
    op(0, 0, 1, 5'h00);
    check("busy_clr", proto_err, 0);
    op(0, 1, 0, 5'h00);
    check("busy_final", {empty, level}, {1'b1, 5'd0});

    // Reset in the RD cycle aborts the pop.
    op(1, 0, 0, 5'h1B);
    void'(mdl.pop_back());
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("abort_in_rd", busy, 1);
    s0 = strobes;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("abort_reset");
    repeat (4) tick();
    check("abort_no_strobe", strobes - s0, 0);
    check_reset("abort_settled");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
